// File: rtl/rs_syndrome_calc.sv
// ----------------------------------------------------------------------------
// rs_syndrome_calc
//   Syndrome front end of the RS(15,11) decoder over GF(16) (x^4+x+1, alpha=2).
//   Symbols arrive highest degree first (r14 .. r0), one per accepted beat.
//   Each beat updates every accumulator by Horner's rule:
//   acc_j = acc_j*alpha^j ^ sym.
//   After the last symbol the four syndromes are registered and presented with a
//   one-cycle strobe.
//
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous active-high reset
//   in_symbol  in   [3:0]  received symbol
//   in_valid   in   in_symbol accepted on this edge
//   syndromes  out  [15:0] {S4,S3,S2,S1}, held until the next syn_valid
//   syn_valid  out  one-cycle pulse when syndromes/syn_error update
//   syn_error  out  any syndrome nonzero
//   sym_index  out  [3:0]  index of the next expected symbol (0..14)
// ----------------------------------------------------------------------------
module rs_syndrome_calc #(
    parameter int unsigned N     = 15,
    parameter int unsigned SYM_W = 4,
    parameter int unsigned NSYN  = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [SYM_W-1:0]        in_symbol,
    input  logic                    in_valid,
    output logic [NSYN*SYM_W-1:0]   syndromes,
    output logic                    syn_valid,
    output logic                    syn_error,
    output logic [3:0]              sym_index
);

    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LAST_IDX = N - 1;

    typedef enum logic {
        ACCUM = 1'b0,
        LAST  = 1'b1
    } state_t;

    state_t                           r_state;
    state_t                           w_state_next;
    logic [IDX_W-1:0]                 r_idx;
    logic [IDX_W-1:0]                 w_idx_next;
    logic [NSYN-1:0][SYM_W-1:0]       r_acc;
    logic [NSYN-1:0][SYM_W-1:0]       w_acc_next;
    logic                             w_syn_load;
    logic [NSYN*SYM_W-1:0]            r_syn;
    logic                             r_syn_valid;
    logic                             r_syn_error;

    // Multiply by alpha: shift left, fold x^4 back as x+1.
    function automatic logic [SYM_W-1:0] mul_alpha(input logic [SYM_W-1:0] a);
        return {a[2], a[1], a[0] ^ a[3], a[3]};
    endfunction

    // Multiply by alpha^j as j chained alpha steps (j <= NSYN).
    function automatic logic [SYM_W-1:0] mul_alpha_pow(input logic [SYM_W-1:0] a,
                                                       input int unsigned    j);
        logic [SYM_W-1:0] v;
        v = a;
        for (int unsigned i = 0; i < NSYN; i++) begin
            if (i < j) begin
                v = mul_alpha(v);
            end
        end
        return v;
    endfunction

    // Next-state, accumulator update and syndrome-load decision.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_acc_next   = r_acc;
        w_syn_load   = 1'b0;
        if (in_valid) begin
            for (int unsigned j = 0; j < NSYN; j++) begin
                // Index 0 loads fresh, dropping whatever the previous frame left.
                if (r_idx == '0) begin
                    w_acc_next[j] = in_symbol;
                end else begin
                    w_acc_next[j] = mul_alpha_pow(r_acc[j], j + 1) ^ in_symbol;
                end
            end
            case (r_state)
                ACCUM: begin
                    w_idx_next = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(LAST_IDX - 1)) begin
                        w_state_next = LAST;
                    end
                end
                LAST: begin
                    w_idx_next   = '0;
                    w_state_next = ACCUM;
                    w_syn_load   = 1'b1;
                end
                default: begin
                    w_idx_next   = '0;
                    w_state_next = ACCUM;
                end
            endcase
        end
    end

    // State, accumulators and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ACCUM;
            r_idx       <= '0;
            r_acc       <= '0;
            r_syn       <= '0;
            r_syn_valid <= 1'b0;
            r_syn_error <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_acc       <= w_acc_next;
            r_syn_valid <= w_syn_load;
            if (w_syn_load) begin
                r_syn       <= w_acc_next;
                r_syn_error <= |w_acc_next;
            end
        end
    end

    assign syndromes = r_syn;
    assign syn_valid = r_syn_valid;
    assign syn_error = r_syn_error;
    assign sym_index = r_idx;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// ----------------------------------------------------------------------------
// tb_rs_syndrome_calc
//   Scoreboard bench. Stimulus pushes the expected syndromes, computed by direct
//   polynomial evaluation S_j = sum r_i * alpha^(i*j) with log/antilog tables,
//   when it drives symbol 14. A negedge monitor pops them on syn_valid and also
//   checks sym_index, latency and the hold behaviour between pulses.
// ----------------------------------------------------------------------------
module tb_rs_syndrome_calc;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  in_symbol = '0;
    logic        in_valid = 1'b0;
    logic [15:0] syndromes;
    logic        syn_valid;
    logic        syn_error;
    logic [3:0]  sym_index;

    rs_syndrome_calc dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_symbol (in_symbol),
        .in_valid  (in_valid),
        .syndromes (syndromes),
        .syn_valid (syn_valid),
        .syn_error (syn_error),
        .sym_index (sym_index)
    );

    always #5 CLK = ~CLK;

    typedef logic [3:0] frame_t [15];
    typedef struct {
        logic [15:0] syn;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          alog[15];
    int          logt[16];
    logic [3:0]  exp_idx = '0;
    logic [15:0] exp_hold = '0;
    logic        exp_err_hold = 1'b0;
    frame_t      cur;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int gf_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return alog[(logt[a] + logt[b]) % 15];
    endfunction

    // f[k] is the k-th symbol sent, i.e. coefficient of x^(14-k).
    function automatic logic [15:0] ref_syn(input frame_t f);
        logic [15:0] r;
        r = '0;
        for (int j = 1; j <= 4; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < 15; k++) begin
                s = s ^ gf_mul(int'(f[k]), alog[(j * (14 - k)) % 15]);
            end
            r[(j-1)*4 +: 4] = 4'(s);
        end
        return r;
    endfunction

    // Monitor: index tracking, pulse timing/content, and hold between pulses.
    always @(negedge CLK) begin
        chk("sym_index", 32'(sym_index), 32'(exp_idx));
        if (syn_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_syn_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("syndromes", 32'(syndromes), 32'(e.syn));
                chk("syn_error", 32'(syn_error), 32'(e.err));
                chk("latency",   32'(cyc),       32'(e.cyc));
                exp_hold     = e.syn;
                exp_err_hold = e.err;
            end
        end else begin
            chk("syn_hold", 32'(syndromes), 32'(exp_hold));
            chk("err_hold", 32'(syn_error), 32'(exp_err_hold));
        end
    end

    task automatic send_sym(input logic [3:0] s);
        in_valid  = 1'b1;
        in_symbol = s;
        @(posedge CLK);
        #1;
        in_valid  = 1'b0;
        in_symbol = 4'($urandom_range(15));
        cur[exp_idx] = s;
        if (exp_idx == 4'd14) begin
            exp_t e;
            e.syn = ref_syn(cur);
            e.err = (e.syn != 16'h0000);
            e.cyc = cyc;
            q.push_back(e);
            exp_idx = '0;
        end else begin
            exp_idx = exp_idx + 4'd1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RESET        = 1'b1;
        exp_idx      = '0;
        exp_hold     = '0;
        exp_err_hold = 1'b0;
        idle(2);
        RESET = 1'b0;
        idle(1);
    endtask

    // Send symbols [0..upto); optional gap after one index and random gaps.
    task automatic send_frame(input frame_t f, input int upto, input int gap_after,
                              input int gap_len, input int gap_pct);
        for (int k = 0; k < upto; k++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle($urandom_range(1, 3));
            send_sym(f[k]);
            if (k == gap_after) idle(gap_len);
        end
    endtask

    function automatic frame_t make_codeword();
        frame_t c;
        int     m[11];
        int     g[5];
        g = '{1, 13, 12, 8, 7};
        for (int i = 0; i < 11; i++) m[i] = int'($urandom_range(15));
        for (int k = 0; k < 15; k++) c[k] = '0;
        for (int i = 0; i < 11; i++)
            for (int j = 0; j < 5; j++)
                c[i+j] = c[i+j] ^ 4'(gf_mul(m[i], g[j]));
        return c;
    endfunction

    initial begin
        frame_t f_zero, f_cw, f_first, f_last, f_rand;
        int v;
        v = 1;
        for (int i = 0; i < 15; i++) begin
            alog[i] = v;
            logt[v] = i;
            v = v << 1;
            if ((v & 16) != 0) v = v ^ 19;
        end
        logt[0] = 0;
        for (int k = 0; k < 15; k++) begin
            f_zero[k]  = '0;
            f_first[k] = '0;
            f_last[k]  = '0;
            f_cw[k]    = '0;
        end
        f_first[0] = 4'd1;
        f_last[14] = 4'd5;
        f_cw[10] = 4'd1; f_cw[11] = 4'd13; f_cw[12] = 4'd12; f_cw[13] = 4'd8; f_cw[14] = 4'd7;

        // Directed checks of the reference model against known answers.
        chk("ref_zero",  32'(ref_syn(f_zero)),  32'h0000);
        chk("ref_cw",    32'(ref_syn(f_cw)),    32'h0000);
        chk("ref_first", 32'(ref_syn(f_first)), 32'hEFD9);
        chk("ref_last",  32'(ref_syn(f_last)),  32'h5555);

        idle(2);
        RESET = 1'b0;
        idle(1);

        send_frame(f_zero, 15, -1, 0, 0);
        send_frame(f_cw, 15, -1, 0, 0);
        send_frame(f_first, 15, -1, 0, 0);
        idle(2);
        send_frame(f_last, 15, -1, 0, 0);
        send_frame(f_first, 15, -1, 0, 0);
        idle(2);
        send_frame(f_first, 15, 6, 3, 0);
        idle(1);
        send_frame(f_first, 9, -1, 0, 0);
        do_reset();
        send_frame(f_cw, 15, -1, 0, 0);
        idle(2);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(1) == 1) begin
                f_rand = make_codeword();
                if ($urandom_range(2) == 0)
                    f_rand[$urandom_range(14)] ^= 4'($urandom_range(1, 15));
            end else begin
                for (int k = 0; k < 15; k++) f_rand[k] = 4'($urandom_range(15));
            end
            if (n % 10 == 7) begin
                send_frame(f_rand, int'($urandom_range(1, 14)), -1, 0, 20);
                do_reset();
            end else begin
                send_frame(f_rand, 15, -1, 0, (n % 3 == 0) ? 0 : 25);
            end
        end
        idle(3);
        chk("pending_pulses", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
